// File: rtl/msg_arbiter_pkg.sv
// Shared definitions for the message arbiter: FSM state constants,
// default message width and the frame/gap counter sizing helper.
package msg_arbiter_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_SEND = 2'd1;
    localparam state_t ST_GAP  = 2'd2;

    localparam int DEF_MSG_W = 5;

    // Counter must reach max(frame, gap) - 1; never narrower than one bit.
    function automatic int cnt_width(input int frame_cycles, input int gap_cycles);
        int m;
        m = (frame_cycles > gap_cycles) ? frame_cycles : gap_cycles;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/msg_arbiter_rr_pick.sv
// Combinational round-robin picker. The request vector is doubled and
// read starting just after the previous grantee, so the lowest set bit
// of the rotated view is the next requester in circular order.
module rr_pick
    import msg_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last_grant,
    output logic             valid,
    output logic [ID_W-1:0]  win
);

    logic [2*N_REQ-1:0] dbl_s;
    logic [N_REQ-1:0]   rot_s;
    logic [ID_W:0]      start_s;
    logic [ID_W:0]      sum_s;
    logic [ID_W-1:0]    off_s;

    // Rotate the request vector so the search begins after the last grantee.
    always_comb begin
        dbl_s = {req, req};
        if ({1'b0, last_grant} >= (ID_W+1)'(N_REQ - 1)) begin
            start_s = '0;
        end else begin
            start_s = {1'b0, last_grant} + (ID_W+1)'(1);
        end
        rot_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rot_s[i] = dbl_s[int'(start_s) + i];
        end
    end

    // Priority search for the lowest set bit, then map back to an index.
    always_comb begin
        valid = |req;
        off_s = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot_s[i]) begin
                off_s = ID_W'(i);
            end else begin
                off_s = off_s;
            end
        end
        sum_s = start_s + {1'b0, off_s};
        if (sum_s >= (ID_W+1)'(N_REQ)) begin
            win = ID_W'(sum_s - (ID_W+1)'(N_REQ));
        end else begin
            win = sum_s[ID_W-1:0];
        end
    end

endmodule

// File: rtl/msg_arbiter.sv
// Round-robin controller sharing one serializer among N_REQ requesters.
// Each grant drives send/msg for exactly FRAME_CYCLES cycles, followed by
// GAP_CYCLES idle cycles before the next arbitration. All outputs are
// registered; requests and messages are only looked at in IDLE.
module msg_arbiter
    import msg_arbiter_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int MSG_W        = DEF_MSG_W,
    parameter int FRAME_CYCLES = 16,
    parameter int GAP_CYCLES   = 2,
    parameter int ID_W         = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*MSG_W-1:0] msg_in,
    output logic [N_REQ-1:0]       ack,
    output logic [N_REQ-1:0]       done,
    output logic                   sp_send,
    output logic [MSG_W-1:0]       sp_msg,
    output logic                   busy,
    output logic [ID_W-1:0]        cur_id
);

    localparam int CNT_W = cnt_width(FRAME_CYCLES, GAP_CYCLES);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [ID_W-1:0]  GRANT_INIT = ID_W'(N_REQ - 1);

    state_t          state_r;
    state_t          state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic [ID_W-1:0]  last_grant_r;
    logic [ID_W-1:0]  last_grant_s;
    logic [N_REQ-1:0] ack_s;
    logic [N_REQ-1:0] done_s;
    logic             send_s;
    logic [MSG_W-1:0] msg_s;
    logic             busy_s;
    logic [ID_W-1:0]  id_s;
    logic             pick_valid_s;
    logic [ID_W-1:0]  pick_win_s;

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req        (req),
        .last_grant (last_grant_r),
        .valid      (pick_valid_s),
        .win        (pick_win_s)
    );

    // Next-state and next-output logic for the IDLE/SEND/GAP sequence.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        last_grant_s = last_grant_r;
        ack_s        = '0;
        done_s       = '0;
        send_s       = sp_send;
        msg_s        = sp_msg;
        busy_s       = busy;
        id_s         = cur_id;
        case (state_r)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    state_s           = ST_SEND;
                    cnt_s             = '0;
                    last_grant_s      = pick_win_s;
                    id_s              = pick_win_s;
                    ack_s[pick_win_s] = 1'b1;
                    send_s            = 1'b1;
                    msg_s             = msg_in[pick_win_s*MSG_W +: MSG_W];
                    busy_s            = 1'b1;
                end else begin
                    send_s = 1'b0;
                    busy_s = 1'b0;
                end
            end
            ST_SEND: begin
                if (cnt_r == FRAME_LAST) begin
                    done_s[cur_id] = 1'b1;
                    send_s         = 1'b0;
                    cnt_s          = '0;
                    state_s        = ST_GAP;
                end else begin
                    cnt_s = cnt_r + 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_r == GAP_LAST) begin
                    state_s = ST_IDLE;
                    cnt_s   = '0;
                    busy_s  = 1'b0;
                end else begin
                    cnt_s = cnt_r + 1'b1;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = '0;
                send_s  = 1'b0;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State, counter and output registers; reset aborts any frame at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            cnt_r        <= '0;
            last_grant_r <= GRANT_INIT;
            ack          <= '0;
            done         <= '0;
            sp_send      <= 1'b0;
            sp_msg       <= '0;
            busy         <= 1'b0;
            cur_id       <= '0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            last_grant_r <= last_grant_s;
            ack          <= ack_s;
            done         <= done_s;
            sp_send      <= send_s;
            sp_msg       <= msg_s;
            busy         <= busy_s;
            cur_id       <= id_s;
        end
    end

endmodule
